spu_pc_gen: RTL and testbench

//  Parametrised SPU fetch-address generator. Issues one fetch PC per cycle, advancing by INC bytes.

---
 rtl/spu_pc_gen.sv | 171 +++++++++++++++++
 tb/tb_spu_pc_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spu_pc_gen.sv
// ---------------------------------------------------------------------------
// spu_pc_gen
//   SPU fetch-address generator. Issues one fetch PC per cycle and advances it
//   by INC bytes. A branch redirect is taken once per rising edge of
//   redirect_i. A circular history of issued PCs allows earlier PCs to be
//   re-issued (replayed). The block sits ahead of IF and drives if_pc/cache.
//
// Ports
//   clk              in   clock, all state on posedge
//   rst              in   synchronous active-high reset
//   stall_i          in   hold the current PC
//   redirect_i       in   branch redirect request (level, edge-qualified)
//   redirect_addr_i  in   redirect target
//   replay_i         in   re-issue a previously issued PC
//   replay_idx_i     in   0 = most recent previous PC, k = k+1 issues back
//   pc_o             out  current fetch address
//   ce_o             out  cache/chip enable
//   pc_valid_o       out  pc_o is newly issued this cycle
//   misalign_o       out  1-cycle pulse: redirect target was not INC aligned
//   replay_err_o     out  1-cycle pulse: replay index beyond history count
// ---------------------------------------------------------------------------
module spu_pc_gen #(
   parameter int ADDR_W     = 32,
   parameter int INC        = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int HIST_DEPTH = 4,
   parameter int IDX_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_addr_i,
   input  logic              replay_i,
   input  logic [IDX_W-1:0]  replay_idx_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              ce_o,
   output logic              pc_valid_o,
   output logic              misalign_o,
   output logic              replay_err_o
);

   typedef enum logic [1:0] {S_OFF, S_START, S_RUN} state_t;

   // What the RUN state does this cycle; exactly one is chosen.
   typedef enum logic [2:0] {
      ACT_REDIRECT, ACT_REPLAY, ACT_REPLAY_ERR, ACT_STALL, ACT_INC
   } action_t;

   localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(INC - 1);
   localparam logic [ADDR_W-1:0] INC_VAL  = ADDR_W'(INC);
   localparam logic [IDX_W:0]    CNT_MAX  = (IDX_W+1)'(HIST_DEPTH);

   state_t            state;
   action_t           action;
   logic              redir_armed;
   logic [IDX_W:0]    hist_cnt;     // number of valid history entries
   logic [IDX_W-1:0]  wr_ptr;       // slot the next pushed PC lands in
   logic [IDX_W-1:0]  rd_ptr;
   logic [IDX_W:0]    idx_ext;
   logic              hist_push;
   logic [ADDR_W-1:0] hist_mem [HIST_DEPTH];

   // Newest entry lives just below wr_ptr; index k walks k slots further back.
   assign rd_ptr  = wr_ptr - IDX_W'(1) - replay_idx_i;
   assign idx_ext = {1'b0, replay_idx_i};

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      action = ACT_INC;
      if (redirect_i && redir_armed)
         action = ACT_REDIRECT;
      else if (replay_i)
         action = (idx_ext < hist_cnt) ? ACT_REPLAY : ACT_REPLAY_ERR;
      else if (stall_i)
         action = ACT_STALL;
   end

   // Leaving START always issues the sequential successor, which records the
   // START PC in history just like a RUN increment.
   assign hist_push = !rst &&
                      ((state == S_START) || (state == S_RUN && action == ACT_INC));

   // NOTE: the history array has no reset; hist_cnt alone says which slots are
   // meaningful, so clearing the storage would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (hist_push)
         hist_mem[wr_ptr] <= pc_o;
   end

   // NOTE: all state below updates with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_OFF;
         pc_o         <= RESET_PC;
         ce_o         <= 1'b0;
         pc_valid_o   <= 1'b0;
         misalign_o   <= 1'b0;
         replay_err_o <= 1'b0;
         hist_cnt     <= '0;
         wr_ptr       <= '0;
         redir_armed  <= 1'b1;
      end else begin
         // Pulses and the valid flag default low; the chosen action raises them.
         pc_valid_o   <= 1'b0;
         misalign_o   <= 1'b0;
         replay_err_o <= 1'b0;

         case (state)
            S_OFF: begin
               state      <= S_START;
               ce_o       <= 1'b1;
               pc_o       <= RESET_PC;
               pc_valid_o <= 1'b1;
            end

            // Requests are ignored here and redir_armed is left alone, so a
            // redirect already high is taken on the first RUN cycle.
            S_START: begin
               state      <= S_RUN;
               pc_o       <= pc_o + INC_VAL;
               pc_valid_o <= 1'b1;
               wr_ptr     <= wr_ptr + IDX_W'(1);
               if (hist_cnt != CNT_MAX)
                  hist_cnt <= hist_cnt + (IDX_W+1)'(1);
            end

            S_RUN: begin
               if (!redirect_i)
                  redir_armed <= 1'b1;

               unique case (action)
                  ACT_REDIRECT: begin
                     pc_o        <= redirect_addr_i & ~OFS_MASK;
                     misalign_o  <= |(redirect_addr_i & OFS_MASK);
                     pc_valid_o  <= 1'b1;
                     hist_cnt    <= '0;
                     redir_armed <= 1'b0;
                  end
                  ACT_REPLAY: begin
                     // Entries newer than the replayed one are discarded too.
                     pc_o       <= hist_mem[rd_ptr];
                     pc_valid_o <= 1'b1;
                     hist_cnt   <= hist_cnt - (idx_ext + (IDX_W+1)'(1));
                     wr_ptr     <= rd_ptr;
                  end
                  ACT_REPLAY_ERR: begin
                     replay_err_o <= 1'b1;
                  end
                  ACT_STALL: begin
                  end
                  ACT_INC: begin
                     pc_o       <= pc_o + INC_VAL;
                     pc_valid_o <= 1'b1;
                     wr_ptr     <= wr_ptr + IDX_W'(1);
                     // At full depth the push overwrites the oldest slot.
                     if (hist_cnt != CNT_MAX)
                        hist_cnt <= hist_cnt + (IDX_W+1)'(1);
                  end
                  default: begin
                  end
               endcase
            end

            default: state <= S_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_spu_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_spu_pc_gen
//   Self-checking bench for spu_pc_gen (ADDR_W=32, INC=8, RESET_PC=0,
//   HIST_DEPTH=4). A table of per-cycle inputs and hand-computed outputs is
//   applied in order from reset, followed by a few hand-written sequences.
// ---------------------------------------------------------------------------
module tb_spu_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_addr_i;
   logic        replay_i;
   logic [1:0]  replay_idx_i;
   logic [31:0] pc_o;
   logic        ce_o;
   logic        pc_valid_o;
   logic        misalign_o;
   logic        replay_err_o;

   int checks   = 0;
   int failures = 0;

   spu_pc_gen #(
      .ADDR_W(32), .INC(8), .RESET_PC(32'h0), .HIST_DEPTH(4), .IDX_W(2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (stall_i),
      .redirect_i     (redirect_i),
      .redirect_addr_i(redirect_addr_i),
      .replay_i       (replay_i),
      .replay_idx_i   (replay_idx_i),
      .pc_o           (pc_o),
      .ce_o           (ce_o),
      .pc_valid_o     (pc_valid_o),
      .misalign_o     (misalign_o),
      .replay_err_o   (replay_err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] addr;
      logic        replay;
      logic [1:0]  idx;
      logic [31:0] pc;
      logic        ce;
      logic        valid;
      logic        mis;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic s, input logic rd,
                               input logic [31:0] a, input logic rp,
                               input logic [1:0] ix, input logic [31:0] p,
                               input logic c, input logic v, input logic m,
                               input logic e);
      vec_t t;
      t.rst = r; t.stall = s; t.redir = rd; t.addr = a; t.replay = rp;
      t.idx = ix; t.pc = p; t.ce = c; t.valid = v; t.mis = m; t.err = e;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] p,
                             input logic c, input logic v, input logic m,
                             input logic e);
      check({tag, " pc_o"},         pc_o,                 p);
      check({tag, " ce_o"},         {31'b0, ce_o},        {31'b0, c});
      check({tag, " pc_valid_o"},   {31'b0, pc_valid_o},  {31'b0, v});
      check({tag, " misalign_o"},   {31'b0, misalign_o},  {31'b0, m});
      check({tag, " replay_err_o"}, {31'b0, replay_err_o},{31'b0, e});
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input vec_t t, input string tag);
      @(negedge clk);
      rst             = t.rst;
      stall_i         = t.stall;
      redirect_i      = t.redir;
      redirect_addr_i = t.addr;
      replay_i        = t.replay;
      replay_idx_i    = t.idx;
      @(posedge clk);
      #1;
      check_outs(tag, t.pc, t.ce, t.valid, t.mis, t.err);
   endtask

   initial begin
      // Watchdog: the run is a few hundred cycles at most.
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
      redirect_addr_i = '0; replay_i = 1'b0; replay_idx_i = '0;

      //            rst st rd addr          rp idx  pc            ce v  m  e
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h0,       1, 1, 0, 0)); //  0 OFF->START
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h8,       1, 1, 0, 0)); //  1 START->RUN
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h10,      1, 1, 0, 0)); //  2
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h18,      1, 1, 0, 0)); //  3 hist 16,8,0
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 1, 32'h8,       1, 1, 0, 0)); //  4 replay 1, cnt 1
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 3, 32'h8,       1, 0, 0, 1)); //  5 idx3 >= cnt1
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h10,      1, 1, 0, 0)); //  6 hist 8,0
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 2, 32'h10,      1, 0, 0, 1)); //  7 idx == cnt
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 1, 32'h0,       1, 1, 0, 0)); //  8 oldest, cnt 0
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h8,       1, 1, 0, 0)); //  9
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 0, 32'h0,       1, 1, 0, 0)); // 10 replay 0
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h8,       1, 1, 0, 0)); // 11
      vecs.push_back(mk(0, 1, 0, 32'h0,      0, 0, 32'h8,       1, 0, 0, 0)); // 12 stall
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h10,      1, 1, 0, 0)); // 13
      vecs.push_back(mk(0, 0, 1, 32'h100,    0, 0, 32'h100,     1, 1, 0, 0)); // 14 redirect
      vecs.push_back(mk(0, 0, 1, 32'h100,    0, 0, 32'h108,     1, 1, 0, 0)); // 15 held: ignored
      vecs.push_back(mk(0, 0, 1, 32'h100,    0, 0, 32'h110,     1, 1, 0, 0)); // 16 held: ignored
      vecs.push_back(mk(0, 0, 0, 32'h100,    0, 0, 32'h118,     1, 1, 0, 0)); // 17 drop, rearm
      vecs.push_back(mk(0, 0, 1, 32'h104,    0, 0, 32'h100,     1, 1, 1, 0)); // 18 misaligned
      vecs.push_back(mk(0, 0, 0, 32'h104,    0, 0, 32'h108,     1, 1, 0, 0)); // 19 pulse ends
      vecs.push_back(mk(0, 1, 1, 32'h200,    0, 0, 32'h200,     1, 1, 0, 0)); // 20 redirect beats stall
      vecs.push_back(mk(0, 1, 1, 32'h204,    0, 0, 32'h200,     1, 0, 0, 0)); // 21 disarmed: stall
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 0, 32'h200,     1, 0, 0, 1)); // 22 history flushed
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h208,     1, 1, 0, 0)); // 23 hist 0x200
      vecs.push_back(mk(0, 0, 1, 32'h300,    1, 0, 32'h300,     1, 1, 0, 0)); // 24 redirect beats replay
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h308,     1, 1, 0, 0)); // 25
      vecs.push_back(mk(0, 0, 1, 32'hFFFFFFF8, 0, 0, 32'hFFFFFFF8, 1, 1, 0, 0)); // 26
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h0,       1, 1, 0, 0)); // 27 wrap to 0
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 0, 32'hFFFFFFF8, 1, 1, 0, 0)); // 28 replay top addr
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h0,       1, 1, 0, 0)); // 29 cnt 1
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h8,       1, 1, 0, 0)); // 30 cnt 2
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h10,      1, 1, 0, 0)); // 31 cnt 3
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h18,      1, 1, 0, 0)); // 32 cnt 4
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h20,      1, 1, 0, 0)); // 33 oldest dropped
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 3, 32'h0,       1, 1, 0, 0)); // 34 deepest = 0
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 0, 32'h0,       1, 0, 0, 1)); // 35 emptied
      vecs.push_back(mk(1, 0, 0, 32'h0,      0, 0, 32'h0,       0, 0, 0, 0)); // 36 reset mid-run
      vecs.push_back(mk(0, 0, 1, 32'h400,    0, 0, 32'h0,       1, 1, 0, 0)); // 37 START, redir ignored
      vecs.push_back(mk(0, 0, 1, 32'h400,    0, 0, 32'h8,       1, 1, 0, 0)); // 38 START exit ignores it
      vecs.push_back(mk(0, 0, 1, 32'h400,    0, 0, 32'h400,     1, 1, 0, 0)); // 39 taken in RUN
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h408,     1, 1, 0, 0)); // 40 hist 0x400
      vecs.push_back(mk(1, 0, 0, 32'h0,      0, 0, 32'h0,       0, 0, 0, 0)); // 41 reset again
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h0,       1, 1, 0, 0)); // 42 START
      vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h8,       1, 1, 0, 0)); // 43 hist 0
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 0, 32'h0,       1, 1, 0, 0)); // 44 replay 0
      vecs.push_back(mk(0, 0, 0, 32'h0,      1, 0, 32'h0,       1, 0, 0, 1)); // 45 0x400 was cleared

      // Reset state after two cycles of rst.
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i], $sformatf("row%0d", i));

      // Sequence A: requests during START are ignored; stall resumes in RUN.
      step(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0), "seqA rst");
      step(mk(0, 1, 0, 32'h0, 1, 0, 32'h0, 1, 1, 0, 0), "seqA start");
      step(mk(0, 1, 0, 32'h0, 1, 0, 32'h8, 1, 1, 0, 0), "seqA exit");
      step(mk(0, 1, 0, 32'h0, 0, 0, 32'h8, 1, 0, 0, 0), "seqA stall");
      step(mk(0, 0, 0, 32'h0, 0, 0, 32'h10, 1, 1, 0, 0), "seqA go");

      // Sequence B: reset wins over a fresh redirect; the redirect is not
      // remembered, and inputs are ignored while reset is held.
      step(mk(0, 0, 1, 32'h507, 0, 0, 32'h500, 1, 1, 1, 0), "seqB redir");
      step(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0), "seqB rst1");
      step(mk(1, 0, 1, 32'h600, 0, 0, 32'h0, 0, 0, 0, 0), "seqB rst2");
      step(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0, 0), "seqB start");
      step(mk(0, 0, 0, 32'h0, 0, 0, 32'h8, 1, 1, 0, 0), "seqB run");
      step(mk(0, 0, 0, 32'h0, 1, 1, 32'h8, 1, 0, 0, 1), "seqB nohist");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
